// File: rtl/grasshopper_round_ctrl.sv
// ----------------------------------------------------------------------------
// grasshopper_round_ctrl
//
// Purpose:
//   Sequences one Grasshopper-style block through NUM_STAGES passes of an
//   external combinational round datapath. The block is captured into a state
//   register and fed out on rnd_data_o together with the stage index. The
//   datapath result comes back on rnd_data_i in the same cycle and is written
//   back into the state register. When the last stage has been applied, the
//   result is held on out_data until the consumer takes it.
//
// Parameters:
//   DATA_W      block width in bits (default 128)
//   NUM_STAGES  stages applied per block, legal range 2..16 (default 10)
//
// Ports:
//   clk           clock, all state changes on the rising edge
//   rst           asynchronous active-high reset
//   in_valid      in_data carries a block to be encoded
//   in_ready      controller can take a block this cycle
//   in_data       plaintext block
//   out_valid     out_data carries a finished block
//   out_ready     consumer takes out_data this cycle
//   out_data      encoded block (mirrors the state register)
//   stage_num_o   stage index for the round datapath (key select), 0 when idle
//   last_stage_o  current stage is the final key-XOR-only stage
//   rnd_data_o    state handed to the round datapath
//   rnd_data_i    round datapath result for the current stage
//   abort_i       drop the block in flight and return to idle
//   busy_o        a block is running or waiting to be taken
//   block_cnt_o   count of completed output transfers, wraps at 16 bits
// ----------------------------------------------------------------------------
module grasshopper_round_ctrl #(
    parameter int DATA_W     = 128,
    parameter int NUM_STAGES = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [3:0]        stage_num_o,
    output logic              last_stage_o,
    output logic [DATA_W-1:0] rnd_data_o,
    input  logic [DATA_W-1:0] rnd_data_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic [15:0]       block_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [3:0] LAST_STG = 4'(NUM_STAGES - 1);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   st_q, st_d;
    logic [3:0]          stg_q, stg_d;
    logic [15:0]         cnt_q, cnt_d;

    logic                accept;
    logic                xfer;

    // Handshake decode. Abort blocks both a new accept and the output
    // transfer, so nothing is counted or captured in an aborted cycle.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: in_ready = ~abort_i;
            RUN:  in_ready = 1'b0;
            HOLD: begin
                out_valid = 1'b1;
                in_ready  = out_ready & ~abort_i;
            end
            default: in_ready = 1'b0;
        endcase
        accept = in_valid & in_ready;
        xfer   = (state_q == HOLD) & out_ready & ~abort_i;
    end

    // Next-state logic. Abort wins over everything else; a transfer out of
    // HOLD and a new accept may happen on the same edge (back-to-back).
    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        stg_d   = stg_q;
        cnt_d   = cnt_q;

        if (abort_i) begin
            state_d = IDLE;
            stg_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        st_d    = in_data;
                        stg_d   = '0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    st_d = rnd_data_i;
                    if (stg_q < LAST_STG) begin
                        stg_d = stg_q + 4'd1;
                    end else begin
                        stg_d   = '0;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (xfer) begin
                        cnt_d   = cnt_q + 16'd1;
                        state_d = IDLE;
                    end
                    if (accept) begin
                        st_d    = in_data;
                        stg_d   = '0;
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                    stg_d   = '0;
                end
            endcase
        end
    end

    // State registers; reset discards any block in flight immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            st_q    <= '0;
            stg_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            stg_q   <= stg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Datapath-facing outputs. The stage index is forced to 0 outside RUN so
    // the key select is quiet while idle or holding.
    always_comb begin
        stage_num_o  = (state_q == RUN) ? stg_q : 4'd0;
        last_stage_o = (state_q == RUN) && (stg_q == LAST_STG);
        busy_o       = (state_q != IDLE);
    end

    assign rnd_data_o  = st_q;
    assign out_data    = st_q;
    assign block_cnt_o = cnt_q;

`ifndef SYNTHESIS
    // A finished block must not change while the consumer stalls.
    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready && !abort_i) |=> (out_valid && $stable(out_data)));

    // Output valid and the last-stage flag only occur while busy.
    a_valid_busy: assert property (@(posedge clk) disable iff (rst)
        (out_valid || last_stage_o) |-> busy_o);
`endif

endmodule

// File: doc/grasshopper_round_ctrl.md
GRASSHOPPER_ROUND_CTRL -- requirements
Module: grasshopper_round_ctrl

Parameters
REQ-001 The block SHALL have parameter DATA_W, default 128, giving the block width in bits.
REQ-002 The block SHALL have parameter NUM_STAGES, default 10, giving the stage count per block; legal range is 2..16.

Interface
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  in_data is valid.
REQ-006 in_ready  output  1  the block can accept a block.
REQ-007 in_data  input  DATA_W  plaintext block.
REQ-008 out_valid  output  1  out_data is valid.
REQ-009 out_ready  input  1  the consumer accepts out_data.
REQ-010 out_data  output  DATA_W  encoded block.
REQ-011 stage_num_o  output  4  current stage index to the round datapath (key select).
REQ-012 last_stage_o  output  1  current stage is the final stage (key-XOR only, no S/L).
REQ-013 rnd_data_o  output  DATA_W  state fed to the combinational round datapath.
REQ-014 rnd_data_i  input  DATA_W  round datapath result, same cycle.
REQ-015 abort_i  input  1  synchronous abort of the current block.
REQ-016 busy_o  output  1  a block is in flight or held.
REQ-017 block_cnt_o  output  16  count of completed output transfers.

Function
REQ-018 The FSM SHALL have three states: IDLE, RUN and HOLD.
REQ-019 The block SHALL hold a DATA_W state register (st) and a 4-bit stage counter (stg).
REQ-020 Accept occurs when in_valid && in_ready; on accept: st<=in_data, stg<=0, state<=RUN.
REQ-021 in_ready SHALL be 1 in IDLE, 1 in HOLD when out_ready=1, 0 in RUN, and 0 whenever abort_i=1.
REQ-022 In RUN, each cycle: st<=rnd_data_i.
REQ-023 In RUN, if stg<NUM_STAGES-1 then stg<=stg+1; otherwise state<=HOLD and stg<=0.
REQ-024 stage_num_o SHALL equal stg in RUN and 0 otherwise.
REQ-025 last_stage_o SHALL be (RUN && stg==NUM_STAGES-1).
REQ-026 rnd_data_o SHALL equal st.
REQ-027 In HOLD, out_valid=1 and out_data=st; both SHALL remain stable until out_ready=1.
REQ-028 out_valid SHALL be 0 in IDLE and RUN; out_data SHALL equal st in all states.
REQ-029 In HOLD with out_ready=1 and no accept: state<=IDLE and block_cnt_o increments.
REQ-030 In HOLD with out_ready=1 and in_valid=1 (back-to-back): block_cnt_o increments and the new accept per REQ-020 applies in the same edge.
REQ-031 Latency: accept at edge T; RUN for NUM_STAGES cycles; out_valid=1 from cycle T+NUM_STAGES+1.
REQ-032 Back-to-back throughput SHALL be one block per NUM_STAGES+1 cycles.
REQ-033 block_cnt_o SHALL wrap from 16'hFFFF to 0.
REQ-034 abort_i=1 SHALL force state<=IDLE and stg<=0 from any state, with highest priority.
REQ-035 On abort, st is unchanged, no count increment occurs, and no accept occurs that cycle.
REQ-036 busy_o SHALL be (state!=IDLE).
REQ-037 in_data, in_valid and rnd_data_i SHALL be ignored outside the conditions above.

Reset
REQ-038 While rst=1, the block SHALL be in IDLE with st=0, stg=0 and block_cnt_o=0.
REQ-039 While rst=1, outputs SHALL be in_ready=1, out_valid=0, busy_o=0, stage_num_o=0 and last_stage_o=0.
REQ-040 Reset asserted mid-RUN or mid-HOLD SHALL discard the block immediately and asynchronously, with no count increment.

Verification
REQ-041 Test stub: rnd_data_i = rnd_data_o ^ {zeros, stage_num_o}. Single block in_data=128'h0 with out_ready=1: out_valid rises 11 cycles after accept, out_data=128'h1, and stage_num_o sequences 0..9.
REQ-042 Backpressure: out_ready=0 for 5 cycles in HOLD -> out_valid and out_data stay stable, in_ready=0, block_cnt_o unchanged; out_ready=1 -> count becomes 1 and state goes to IDLE.
REQ-043 Back-to-back: in_valid held high for 3 blocks -> 3 outputs spaced 11 cycles apart; block_cnt_o=3; last_stage_o pulses once per block.
REQ-044 abort_i pulsed at stage 4 -> state goes to IDLE next cycle, no out_valid, count unchanged; the next block completes correctly.
REQ-045 rst asserted in HOLD -> out_valid=0 immediately (asynchronous); after release in_ready=1 and block_cnt_o=0.
REQ-046 Wrap: preload via 65536 completions (or force) -> block_cnt_o reads 0 after the 65536th transfer.
